// File: rtl/i2c_target_responder.sv
// i2c_target_responder
//   Clock-oversampled I2C target. Detects START/STOP, matches a 7-bit
//   address, ACKs, and then either returns a 16-bit word (MSB byte first,
//   TMP101-style) or hands written bytes to the fabric with a strobe.
//
// Handshake: WriteStrobe is a one-cycle valid pulse with no ready; WriteData
//   and WriteFirst are meaningful only in the cycle WriteStrobe is high.
//   The fabric cannot stall the bus.
//
// Ports
//   Clock       system clock, at least 16x the SCL frequency
//   Reset       synchronous, active-low reset
//   SCL         I2C clock from the controller (input only)
//   SDA         I2C data, open-drain: driven 1'b0 or released (1'bz)
//   ReadData    word returned on reads, latched at the read address ACK
//   WriteData   last byte received in a write transfer
//   WriteStrobe one-cycle pulse when WriteData is updated
//   WriteFirst  high with WriteStrobe for the first byte after the address
//   Busy        high from an address-matched START until STOP
//   DebugState  current FSM state encoding
//
// Optional build macro: I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample stability
//   filter on SCL and SDA after the synchronizers (+2 cycles of latency).
module i2c_target_responder #(
  parameter logic [6:0] ADDRESS = 7'h48
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        SCL,
  inout  wire         SDA,
  input  logic [15:0] ReadData,
  output logic [7:0]  WriteData,
  output logic        WriteStrobe,
  output logic        WriteFirst,
  output logic        Busy,
  output logic [2:0]  DebugState
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_BYTE   = 3'd3,
    WR_ACK    = 3'd4,
    RD_BYTE   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } stateT;

  // Synchronizers reset to 1 so an idle bus produces no edges after reset.
  logic [1:0] sclSync, sdaSync;
  logic       sclS, sdaS;
  logic       sclPrev, sdaPrev;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sclSync <= 2'b11;
      sdaSync <= 2'b11;
    end else begin
      sclSync <= {sclSync[0], SCL};
      sdaSync <= {sdaSync[0], SDA};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  // The filtered level follows the synchronizer only when the current sample
  // and the two before it agree; otherwise the last stable level is held.
  logic [1:0] sclHist, sdaHist;
  logic       sclHeld, sdaHeld;

  always_comb begin
    sclS = sclHeld;
    sdaS = sdaHeld;
    if (sclSync[1] == sclHist[0] && sclHist[0] == sclHist[1]) sclS = sclSync[1];
    if (sdaSync[1] == sdaHist[0] && sdaHist[0] == sdaHist[1]) sdaS = sdaSync[1];
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sclHist <= 2'b11;
      sdaHist <= 2'b11;
      sclHeld <= 1'b1;
      sdaHeld <= 1'b1;
    end else begin
      sclHist <= {sclHist[0], sclSync[1]};
      sdaHist <= {sdaHist[0], sdaSync[1]};
      sclHeld <= sclS;
      sdaHeld <= sdaS;
    end
  end
`else
  assign sclS = sclSync[1];
  assign sdaS = sdaSync[1];
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sclPrev <= 1'b1;
      sdaPrev <= 1'b1;
    end else begin
      sclPrev <= sclS;
      sdaPrev <= sdaS;
    end
  end

  logic sclRise, sclFall, startCond, stopCond;
  assign sclRise   = sclS & ~sclPrev;
  assign sclFall   = ~sclS & sclPrev;
  assign startCond = sclS & sdaPrev & ~sdaS;
  assign stopCond  = sclS & ~sdaPrev & sdaS;

  stateT       state, stateNext;
  logic [2:0]  bitCnt, bitCntNext;
  logic [6:0]  shiftReg, shiftRegNext;
  logic        rwBit, rwBitNext;
  logic        ackPhase, ackPhaseNext;   // 0: waiting to drive, 1: driving
  logic        byteIdx, byteIdxNext;
  logic        firstByte, firstByteNext;
  logic [15:0] latched, latchedNext;
  logic        sdaLow, sdaLowNext;
  logic [7:0]  writeDataNext;
  logic        writeStrobeNext, writeFirstNext, busyNext;
  logic [7:0]  curByte;

  assign curByte    = byteIdx ? latched[7:0] : latched[15:8];
  assign SDA        = sdaLow ? 1'b0 : 1'bz;
  assign DebugState = state;

  always_comb begin
    stateNext       = state;
    bitCntNext      = bitCnt;
    shiftRegNext    = shiftReg;
    rwBitNext       = rwBit;
    ackPhaseNext    = ackPhase;
    byteIdxNext     = byteIdx;
    firstByteNext   = firstByte;
    latchedNext     = latched;
    sdaLowNext      = sdaLow;
    writeDataNext   = WriteData;
    writeStrobeNext = 1'b0;
    writeFirstNext  = 1'b0;
    busyNext        = Busy;

    if (startCond) begin
      // START (including repeated START) beats any same-cycle SCL edge.
      stateNext    = ADDR;
      bitCntNext   = 3'd0;
      ackPhaseNext = 1'b0;
      sdaLowNext   = 1'b0;
    end else if (stopCond) begin
      stateNext    = IDLE;
      ackPhaseNext = 1'b0;
      sdaLowNext   = 1'b0;
      busyNext     = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (sclRise) begin
            shiftRegNext = {shiftReg[5:0], sdaS};
            bitCntNext   = bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              // shiftReg holds the 7 address bits; sdaS is R/W.
              rwBitNext    = sdaS;
              ackPhaseNext = 1'b0;
              if (shiftReg == ADDRESS) begin
                stateNext = ADDR_ACK;
                busyNext  = 1'b1;
              end else begin
                // Also ends a matched transfer redirected by repeated START.
                stateNext = WAIT_STOP;
                busyNext  = 1'b0;
              end
            end
          end
        end
        ADDR_ACK, WR_ACK: begin
          if (sclFall) begin
            if (!ackPhase) begin
              sdaLowNext   = 1'b1;
              ackPhaseNext = 1'b1;
            end else begin
              ackPhaseNext = 1'b0;
              bitCntNext   = 3'd0;
              if (state == ADDR_ACK && rwBit) begin
                // Release of the ACK doubles as presenting the first read bit.
                latchedNext = ReadData;
                byteIdxNext = 1'b0;
                sdaLowNext  = ~ReadData[15];
                stateNext   = RD_BYTE;
              end else begin
                sdaLowNext = 1'b0;
                stateNext  = WR_BYTE;
                if (state == ADDR_ACK) firstByteNext = 1'b1;
              end
            end
          end
        end
        WR_BYTE: begin
          if (sclRise) begin
            shiftRegNext = {shiftReg[5:0], sdaS};
            bitCntNext   = bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              writeDataNext   = {shiftReg, sdaS};
              writeStrobeNext = 1'b1;
              writeFirstNext  = firstByte;
              firstByteNext   = 1'b0;
              ackPhaseNext    = 1'b0;
              stateNext       = WR_ACK;
            end
          end
        end
        RD_BYTE: begin
          if (sclFall) begin
            if (bitCnt == 3'd7) begin
              sdaLowNext   = 1'b0;
              ackPhaseNext = 1'b0;
              stateNext    = RD_ACK;
            end else begin
              bitCntNext = bitCnt + 3'd1;
              sdaLowNext = ~curByte[3'd6 - bitCnt];
            end
          end
        end
        RD_ACK: begin
          if (!ackPhase) begin
            if (sclRise) begin
              if (sdaS) begin
                stateNext = WAIT_STOP;
              end else begin
                ackPhaseNext = 1'b1;
                if (byteIdx) begin
                  byteIdxNext = 1'b0;
                  latchedNext = ReadData;
                end else begin
                  byteIdxNext = 1'b1;
                end
              end
            end
          end else if (sclFall) begin
            // byteIdx already advanced, so curByte is the next byte.
            ackPhaseNext = 1'b0;
            bitCntNext   = 3'd0;
            sdaLowNext   = ~curByte[7];
            stateNext    = RD_BYTE;
          end
        end
        WAIT_STOP: sdaLowNext = 1'b0;
        default:   sdaLowNext = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= IDLE;
      bitCnt      <= 3'd0;
      shiftReg    <= 7'd0;
      rwBit       <= 1'b0;
      ackPhase    <= 1'b0;
      byteIdx     <= 1'b0;
      firstByte   <= 1'b0;
      latched     <= 16'd0;
      sdaLow      <= 1'b0;
      WriteData   <= 8'h00;
      WriteStrobe <= 1'b0;
      WriteFirst  <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      state       <= stateNext;
      bitCnt      <= bitCntNext;
      shiftReg    <= shiftRegNext;
      rwBit       <= rwBitNext;
      ackPhase    <= ackPhaseNext;
      byteIdx     <= byteIdxNext;
      firstByte   <= firstByteNext;
      latched     <= latchedNext;
      sdaLow      <= sdaLowNext;
      WriteData   <= writeDataNext;
      WriteStrobe <= writeStrobeNext;
      WriteFirst  <= writeFirstNext;
      Busy        <= busyNext;
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed testbench for i2c_target_responder: a bit-banged controller drives
// SCL/SDA, a monitor queues every WriteStrobe, and each scenario task checks
// its own results against hand-computed values.
module tb_i2c_target_responder;

  localparam int HALF = 20;  // SCL half period in Clock cycles

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  logic        Clock;
  logic        Reset;
  logic        scl;
  logic        ctrlSdaLow;
  logic [15:0] readData;
  logic [7:0]  writeData;
  logic        writeStrobe;
  logic        writeFirst;
  logic        busy;
  logic [2:0]  debugState;
  wire         sdaBus;

  assign sdaBus = ctrlSdaLow ? 1'b0 : 1'bz;
  pullup (sdaBus);

  i2c_target_responder #(.ADDRESS(7'h48)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .SCL        (scl),
    .SDA        (sdaBus),
    .ReadData   (readData),
    .WriteData  (writeData),
    .WriteStrobe(writeStrobe),
    .WriteFirst (writeFirst),
    .Busy       (busy),
    .DebugState (debugState)
  );

  // Clock / reset block
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int compared   = 0;
  int mismatched = 0;

  // Scoreboard: {WriteFirst, WriteData} per strobe
  logic [8:0] expQ[$];
  logic [8:0] obsQ[$];

  always @(negedge Clock) begin
    if (Reset && writeStrobe) obsQ.push_back({writeFirst, writeData});
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic clockBit(input logic drive, output logic seen);
    tick(4);
    ctrlSdaLow = ~drive;
    tick(HALF - 4);
    scl = 1'b1;
    tick(HALF / 2);
    seen = sdaBus;
    tick(HALF / 2);
    scl = 1'b0;
  endtask

  task automatic i2cStart();
    ctrlSdaLow = 1'b0;
    tick(HALF);
    scl = 1'b1;
    tick(HALF);
    ctrlSdaLow = 1'b1;
    tick(HALF);
    scl = 1'b0;
  endtask

  task automatic i2cStop();
    tick(4);
    ctrlSdaLow = 1'b1;
    tick(HALF - 4);
    scl = 1'b1;
    tick(HALF);
    ctrlSdaLow = 1'b0;
    tick(HALF);
  endtask

  task automatic writeByte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clockBit(b[i], s);
    clockBit(1'b1, s);
    ack = s;
  endtask

  task automatic readByte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clockBit(1'b1, s);
      d[i] = s;
    end
    clockBit(nack, s);
  endtask

  // Scenarios
  task automatic test_reset();
    Reset = 1'b0;
    tick(3);
    compared++;
    if (writeData !== 8'h00) begin mismatched++; $display("FAIL reset_wdata: got %h want 00", writeData); end
    compared++;
    if (writeStrobe !== 1'b0) begin mismatched++; $display("FAIL reset_strobe: got %b want 0", writeStrobe); end
    compared++;
    if (writeFirst !== 1'b0) begin mismatched++; $display("FAIL reset_first: got %b want 0", writeFirst); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++;
    if (sdaBus !== 1'b1) begin mismatched++; $display("FAIL reset_sda: got %b want 1 (released)", sdaBus); end
    compared++;
    if (debugState !== S_IDLE) begin mismatched++; $display("FAIL reset_state: got %0d want %0d", debugState, S_IDLE); end
    Reset = 1'b1;
    tick(5);
  endtask

  task automatic test_write();
    logic ack;
    logic [8:0] e, o;
    obsQ.delete();
    expQ.delete();
    expQ.push_back({1'b1, 8'h01});
    expQ.push_back({1'b0, 8'h60});
    i2cStart();
    writeByte(8'h90, ack);
    compared++;
    if (ack !== 1'b0) begin mismatched++; $display("FAIL write_addr_ack: got %b want 0", ack); end
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL write_busy: got %b want 1", busy); end
    writeByte(8'h01, ack);
    compared++;
    if (ack !== 1'b0) begin mismatched++; $display("FAIL write_ptr_ack: got %b want 0", ack); end
    writeByte(8'h60, ack);
    compared++;
    if (ack !== 1'b0) begin mismatched++; $display("FAIL write_data_ack: got %b want 0", ack); end
    i2cStop();
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL write_busy_stop: got %b want 0", busy); end
    compared++;
    if (writeData !== 8'h60) begin mismatched++; $display("FAIL write_wdata_hold: got %h want 60", writeData); end
    compared++;
    if (obsQ.size() !== expQ.size()) begin mismatched++; $display("FAIL write_strobe_count: got %0d want %0d", obsQ.size(), expQ.size()); end
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      o = obsQ.pop_front();
      e = expQ.pop_front();
      compared++;
      if (o !== e) begin mismatched++; $display("FAIL write_strobe_data: got first=%b data=%h want first=%b data=%h", o[8], o[7:0], e[8], e[7:0]); end
    end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] d;
    readData = 16'h1930;
    i2cStart();
    writeByte(8'h91, ack);
    compared++;
    if (ack !== 1'b0) begin mismatched++; $display("FAIL read_addr_ack: got %b want 0", ack); end
    tick(8);
    readData = 16'hAAAA;  // must not affect the word latched at the ACK
    readByte(1'b0, d);
    compared++;
    if (d !== 8'h19) begin mismatched++; $display("FAIL read_byte0: got %h want 19", d); end
    readByte(1'b1, d);
    compared++;
    if (d !== 8'h30) begin mismatched++; $display("FAIL read_byte1: got %h want 30", d); end
    tick(8);
    compared++;
    if (debugState !== S_WAIT_STOP) begin mismatched++; $display("FAIL read_wait_stop: got %0d want %0d", debugState, S_WAIT_STOP); end
    compared++;
    if (sdaBus !== 1'b1) begin mismatched++; $display("FAIL read_sda_released: got %b want 1", sdaBus); end
    i2cStop();
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL read_busy_stop: got %b want 0", busy); end
  endtask

  task automatic test_nomatch();
    logic ack;
    obsQ.delete();
    i2cStart();
    writeByte(8'h92, ack);
    compared++;
    if (ack !== 1'b1) begin mismatched++; $display("FAIL nomatch_ack: got %b want 1 (no ACK)", ack); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL nomatch_busy: got %b want 0", busy); end
    compared++;
    if (debugState !== S_WAIT_STOP) begin mismatched++; $display("FAIL nomatch_state: got %0d want %0d", debugState, S_WAIT_STOP); end
    writeByte(8'h55, ack);
    compared++;
    if (ack !== 1'b1) begin mismatched++; $display("FAIL nomatch_data_ack: got %b want 1", ack); end
    i2cStop();
    compared++;
    if (obsQ.size() !== 0) begin mismatched++; $display("FAIL nomatch_strobe: got %0d strobes want 0", obsQ.size()); end
  endtask

  task automatic test_back_to_back();
    logic ack;
    logic [7:0] d;
    logic [8:0] o;
    obsQ.delete();
    i2cStart();
    writeByte(8'h90, ack);
    compared++;
    if (ack !== 1'b0) begin mismatched++; $display("FAIL rs_addr_ack: got %b want 0", ack); end
    writeByte(8'h00, ack);
    compared++;
    if (ack !== 1'b0) begin mismatched++; $display("FAIL rs_ptr_ack: got %b want 0", ack); end
    readData = 16'h7FF0;
    i2cStart();
    writeByte(8'h91, ack);
    compared++;
    if (ack !== 1'b0) begin mismatched++; $display("FAIL rs_read_addr_ack: got %b want 0", ack); end
    readByte(1'b0, d);
    compared++;
    if (d !== 8'h7F) begin mismatched++; $display("FAIL rs_byte0: got %h want 7f", d); end
    readByte(1'b1, d);
    compared++;
    if (d !== 8'hF0) begin mismatched++; $display("FAIL rs_byte1: got %h want f0", d); end
    i2cStop();
    compared++;
    if (obsQ.size() !== 1) begin mismatched++; $display("FAIL rs_strobe_count: got %0d want 1", obsQ.size()); end
    if (obsQ.size() > 0) begin
      o = obsQ.pop_front();
      compared++;
      if (o !== {1'b1, 8'h00}) begin mismatched++; $display("FAIL rs_strobe_data: got first=%b data=%h want first=1 data=00", o[8], o[7:0]); end
    end
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    logic [7:0] d;
    readData = 16'h0000;
    i2cStart();
    writeByte(8'h91, ack);
    tick(10);
    compared++;
    if (sdaBus !== 1'b0) begin mismatched++; $display("FAIL midrst_driving: got %b want 0", sdaBus); end
    Reset = 1'b0;
    tick(1);
    compared++;
    if (sdaBus !== 1'b1) begin mismatched++; $display("FAIL midrst_sda: got %b want 1 (released)", sdaBus); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL midrst_busy: got %b want 0", busy); end
    compared++;
    if (debugState !== S_IDLE) begin mismatched++; $display("FAIL midrst_state: got %0d want %0d", debugState, S_IDLE); end
    Reset = 1'b1;
    scl = 1'b1;
    tick(HALF);
    readData = 16'h5AC3;
    i2cStart();
    writeByte(8'h91, ack);
    compared++;
    if (ack !== 1'b0) begin mismatched++; $display("FAIL midrst_addr_ack: got %b want 0", ack); end
    readByte(1'b0, d);
    compared++;
    if (d !== 8'h5A) begin mismatched++; $display("FAIL midrst_byte0: got %h want 5a", d); end
    readByte(1'b1, d);
    compared++;
    if (d !== 8'hC3) begin mismatched++; $display("FAIL midrst_byte1: got %h want c3", d); end
    i2cStop();
  endtask

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic ack;
    ctrlSdaLow = 1'b1;
    tick(2);
    ctrlSdaLow = 1'b0;
    tick(20);
    compared++;
    if (debugState !== S_IDLE) begin mismatched++; $display("FAIL glitch_state: got %0d want %0d", debugState, S_IDLE); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL glitch_busy: got %b want 0", busy); end
    i2cStart();
    writeByte(8'h90, ack);
    compared++;
    if (ack !== 1'b0) begin mismatched++; $display("FAIL glitch_after_ack: got %b want 0", ack); end
    i2cStop();
  endtask
`endif

  initial begin
    Reset      = 1'b0;
    scl        = 1'b1;
    ctrlSdaLow = 1'b0;
    readData   = 16'h0000;
    tick(2);
    test_reset();
    test_write();
    test_read();
    test_nomatch();
    test_back_to_back();
    test_reset_mid_read();
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    test_glitch();
`endif
    tick(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
